// File: rtl/mult_bus_pkg.sv
// ---------------------------------------------------------------------------
// mult_bus_pkg
// Shared definitions for the multiplier bus master:
//   - mb_state_t : FSM state encoding of mult_bus_master
//   - MB_ADDR_*  : default peripheral register map
//   - INIT_*     : data words written to the init register
//   - MB_TIMEOUT : default poll budget before a request is aborted
// ---------------------------------------------------------------------------
package mult_bus_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_A     = 3'd1,
        WR_B     = 3'd2,
        INIT_SET = 3'd3,
        INIT_CLR = 3'd4,
        POLL     = 3'd5,
        RD_RES   = 3'd6,
        RESP     = 3'd7
    } mb_state_t;

    // Peripheral register map
    localparam logic [4:0] MB_ADDR_A    = 5'h04;
    localparam logic [4:0] MB_ADDR_B    = 5'h08;
    localparam logic [4:0] MB_ADDR_INIT = 5'h0C;
    localparam logic [4:0] MB_ADDR_RES  = 5'h10;
    localparam logic [4:0] MB_ADDR_DONE = 5'h14;

    // Init is pulsed: written 1 to start (and clear done), then written 0
    localparam logic [15:0] INIT_SET_DATA = 16'h0001;
    localparam logic [15:0] INIT_CLR_DATA = 16'h0000;

    localparam int MB_TIMEOUT = 1024;

endpackage : mult_bus_pkg

// File: rtl/mult_bus_master.sv
// ---------------------------------------------------------------------------
// mult_bus_master
// Bus initiator for the multiplier peripheral. Takes an operand pair on a
// valid/ready request port, writes A, B and an init pulse to the
// peripheral, polls done, reads the 32-bit product and presents it on a
// valid/ready response port. A poll budget of TIMEOUT reads aborts the
// transaction with rsp_err=1 and rsp_data=0.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   req_valid/req_ready    request handshake, operands req_a / req_b (16b)
//   rsp_valid/rsp_ready    response handshake, rsp_data (32b), rsp_err
//   bus_cs/addr/rd/wr      peripheral access strobes (Moore, from state)
//   bus_wdata              write data (16b)
//   bus_rdata              read data (32b), combinational from cs/addr
// ---------------------------------------------------------------------------
module mult_bus_master
    import mult_bus_pkg::*;
#(
    parameter logic [4:0] ADDR_A    = MB_ADDR_A,
    parameter logic [4:0] ADDR_B    = MB_ADDR_B,
    parameter logic [4:0] ADDR_INIT = MB_ADDR_INIT,
    parameter logic [4:0] ADDR_RES  = MB_ADDR_RES,
    parameter logic [4:0] ADDR_DONE = MB_ADDR_DONE,
    parameter int         TIMEOUT   = MB_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    // request port
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    // response port
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    // peripheral bus
    output logic        bus_cs,
    output logic [4:0]  bus_addr,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [15:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Value of the counter on the last allowed poll read
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] POLL_MAX  = CNT_W'(TIMEOUT);

    mb_state_t        state_q,    state_d;
    logic [15:0]      a_q,        a_d;
    logic [15:0]      b_q,        b_d;
    logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_err_q,  rsp_err_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            poll_cnt_q <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            poll_cnt_q <= poll_cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // NOTE: every variable driven here gets a default first; any path through
    // the case that skips an assignment would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        poll_cnt_d = poll_cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        bus_cs     = 1'b0;
        bus_rd     = 1'b0;
        bus_wr     = 1'b0;
        bus_addr   = '0;
        bus_wdata  = '0;

        req_ready  = 1'b0;
        rsp_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    state_d = WR_A;
                end
            end

            WR_A: begin
                bus_cs    = 1'b1;
                bus_wr    = 1'b1;
                bus_addr  = ADDR_A;
                bus_wdata = a_q;
                state_d   = WR_B;
            end

            WR_B: begin
                bus_cs    = 1'b1;
                bus_wr    = 1'b1;
                bus_addr  = ADDR_B;
                bus_wdata = b_q;
                state_d   = INIT_SET;
            end

            INIT_SET: begin
                bus_cs    = 1'b1;
                bus_wr    = 1'b1;
                bus_addr  = ADDR_INIT;
                bus_wdata = INIT_SET_DATA;
                state_d   = INIT_CLR;
            end

            INIT_CLR: begin
                bus_cs     = 1'b1;
                bus_wr     = 1'b1;
                bus_addr   = ADDR_INIT;
                bus_wdata  = INIT_CLR_DATA;
                poll_cnt_d = '0;
                state_d    = POLL;
            end

            POLL: begin
                bus_cs   = 1'b1;
                bus_rd   = 1'b1;
                bus_addr = ADDR_DONE;
                if (bus_rdata[0]) begin
                    state_d = RD_RES;
                end else if (poll_cnt_q == POLL_LAST) begin
                    // Budget exhausted: report an error with a zero product
                    poll_cnt_d = POLL_MAX;
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                    state_d    = RESP;
                end else begin
                    poll_cnt_d = poll_cnt_q + CNT_W'(1);
                end
            end

            RD_RES: begin
                bus_cs     = 1'b1;
                bus_rd     = 1'b1;
                bus_addr   = ADDR_RES;
                rsp_data_d = bus_rdata;
                rsp_err_d  = 1'b0;
                state_d    = RESP;
            end

            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule : mult_bus_master

// File: tb/tb_mult_bus_master.sv
// ---------------------------------------------------------------------------
// tb_mult_bus_master
// Directed bench for mult_bus_master with a behavioural multiplier
// peripheral attached. The peripheral raises done a programmable number of
// cycles after init is written 1, or never when stuck_low is set.
// ---------------------------------------------------------------------------
module tb_mult_bus_master;
    import mult_bus_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        bus_cs;
    logic [4:0]  bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic [15:0] bus_wdata;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    mult_bus_master #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .bus_cs    (bus_cs),
        .bus_addr  (bus_addr),
        .bus_rd    (bus_rd),
        .bus_wr    (bus_wr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    // ---------------- behavioural peripheral ----------------
    int          lat = 0;
    bit          stuck_low = 1'b0;
    logic [15:0] p_a, p_b;
    logic [31:0] p_res;
    logic        p_done, p_busy;
    int          p_cnt;

    always @(posedge clk) begin
        if (reset) begin
            p_a <= '0; p_b <= '0; p_res <= '0;
            p_done <= 1'b0; p_busy <= 1'b0; p_cnt <= 0;
        end else begin
            if (p_busy) begin
                if (p_cnt == 0) begin
                    p_busy <= 1'b0;
                    p_done <= !stuck_low;
                    p_res  <= 32'(p_a) * 32'(p_b);
                end else begin
                    p_cnt <= p_cnt - 1;
                end
            end
            if (bus_cs && bus_wr) begin
                if (bus_addr == 5'h04) p_a <= bus_wdata;
                if (bus_addr == 5'h08) p_b <= bus_wdata;
                if (bus_addr == 5'h0C && bus_wdata[0]) begin
                    p_done <= 1'b0;
                    p_busy <= 1'b1;
                    p_cnt  <= lat;
                end
            end
        end
    end

    always_comb begin
        bus_rdata = '0;
        if (bus_cs && bus_addr == 5'h10) bus_rdata = p_res;
        if (bus_cs && bus_addr == 5'h14) bus_rdata = {31'b0, p_done};
    end

    // ---------------- bus trace ----------------
    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [4:0] addr;
        logic [15:0] wdata;
    } acc_t;

    acc_t trace[$];

    always @(negedge clk) begin
        if (bus_cs === 1'b1) trace.push_back(acc_t'{bus_rd, bus_wr, bus_addr, bus_wdata});
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns just after the accept edge.
    task automatic send_req(input logic [15:0] a, input logic [15:0] b);
        int guard = 0;
        while (req_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_before_send", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        // Operand changes after acceptance must not reach the bus
        req_a     = 16'hDEAD;
        req_b     = 16'hBEEF;
    endtask

    // Counts negedges after the accept edge until rsp_valid (bounded).
    task automatic wait_rsp(output logic [31:0] data, output logic err, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (rsp_valid !== 1'b1 && cycles < 200);
        check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
        data = rsp_data;
        err  = rsp_err;
    endtask

    // Called at a negedge with rsp_valid high; ends at a negedge in IDLE.
    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          lat;
        logic [31:0] exp;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[5];
        acc_t        exp_tr[$];
        logic [31:0] d;
        logic        e;
        int          cyc;
        int          n_done_rd, n_res_rd, guard;
        bit          stable;

        vecs[0] = '{16'd3,    16'd5,    0, 32'd15};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 2, 32'hFFFE0001};
        vecs[2] = '{16'h0000, 16'h1234, 1, 32'h0};
        vecs[3] = '{16'h8000, 16'h0002, 3, 32'h00010000};
        vecs[4] = '{16'h00FF, 16'h0101, 4, 32'h0000FFFF};

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_data",  rsp_data, 32'd0);
        check("rst rsp_err",   32'(rsp_err), 32'd0);
        check("rst bus_strobes", {29'b0, bus_cs, bus_rd, bus_wr}, 32'd0);
        check("rst bus_addr",  32'(bus_addr), 32'd0);
        check("rst bus_wdata", 32'(bus_wdata), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // ---- table-driven products with full bus trace ----
        foreach (vecs[i]) begin
            lat = vecs[i].lat;
            trace.delete();
            send_req(vecs[i].a, vecs[i].b);
            wait_rsp(d, e, cyc);
            check($sformatf("vec%0d data", i), d, vecs[i].exp);
            check($sformatf("vec%0d err", i), 32'(e), 32'd0);
            check($sformatf("vec%0d latency", i), 32'(cyc), 32'(7 + vecs[i].lat));

            exp_tr.delete();
            exp_tr.push_back(acc_t'{1'b0, 1'b1, 5'h04, vecs[i].a});
            exp_tr.push_back(acc_t'{1'b0, 1'b1, 5'h08, vecs[i].b});
            exp_tr.push_back(acc_t'{1'b0, 1'b1, 5'h0C, 16'h0001});
            exp_tr.push_back(acc_t'{1'b0, 1'b1, 5'h0C, 16'h0000});
            for (int k = 0; k <= vecs[i].lat; k++) exp_tr.push_back(acc_t'{1'b1, 1'b0, 5'h14, 16'h0});
            exp_tr.push_back(acc_t'{1'b1, 1'b0, 5'h10, 16'h0});

            check($sformatf("vec%0d trace_len", i), 32'(trace.size()), 32'(exp_tr.size()));
            for (int k = 0; k < exp_tr.size() && k < trace.size(); k++)
                check($sformatf("vec%0d trace[%0d]", i, k), 32'(trace[k]), 32'(exp_tr[k]));
            finish_rsp();
        end

        // ---- back-pressure, with a competing request held high ----
        lat = 1;
        send_req(16'd6, 16'd7);
        wait_rsp(d, e, cyc);
        check("bp data", d, 32'd42);
        req_valid = 1'b1;
        req_a     = 16'd11;
        req_b     = 16'd13;
        stable    = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== 32'd42 || rsp_err !== 1'b0 ||
                req_ready !== 1'b0 || bus_cs !== 1'b0) stable = 1'b0;
        end
        check("bp stable_window", 32'(stable), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("bp idle req_ready", 32'(req_ready), 32'd1);
        check("bp idle rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("bp 2nd wr_a", {bus_cs, bus_wr, 9'b0, bus_addr, bus_wdata}, {1'b1, 1'b1, 9'b0, 5'h04, 16'd11});
        wait_rsp(d, e, cyc);
        check("bp 2nd data", d, 32'd143);
        finish_rsp();

        // ---- poll timeout ----
        stuck_low = 1'b1;
        lat       = 0;
        trace.delete();
        send_req(16'd5, 16'd5);
        wait_rsp(d, e, cyc);
        check("to err", 32'(e), 32'd1);
        check("to data", d, 32'd0);
        check("to latency", 32'(cyc), 32'd13);
        n_done_rd = 0;
        n_res_rd  = 0;
        foreach (trace[k]) begin
            if (trace[k].rd && trace[k].addr == 5'h14) n_done_rd++;
            if (trace[k].rd && trace[k].addr == 5'h10) n_res_rd++;
        end
        check("to done_reads", 32'(n_done_rd), 32'(TO));
        check("to res_reads", 32'(n_res_rd), 32'd0);
        finish_rsp();
        stuck_low = 1'b0;

        // ---- reset during POLL ----
        lat = 5;
        send_req(16'd20, 16'd30);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(bus_cs === 1'b1 && bus_addr === 5'h14) && guard < 50);
        check("rst_mid reached_poll", 32'(bus_addr), 32'h14);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid strobes", {29'b0, bus_cs, bus_rd, bus_wr}, 32'd0);
        check("rst_mid req_ready", 32'(req_ready), 32'd1);
        check("rst_mid rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        lat   = 0;
        @(negedge clk);
        send_req(16'd7, 16'd9);
        wait_rsp(d, e, cyc);
        check("rst_mid new data", d, 32'd63);
        finish_rsp();

        // ---- back-to-back with rsp_ready tied high ----
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_a     = 16'd2;
        req_b     = 16'd2;
        @(posedge clk);
        #1;
        req_a = 16'd100;
        req_b = 16'd100;
        wait_rsp(d, e, cyc);
        check("b2b first data", d, 32'd4);
        @(posedge clk);
        @(negedge clk);
        check("b2b gap req_ready", 32'(req_ready), 32'd1);
        check("b2b gap rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("b2b 2nd wr_a", {bus_cs, bus_wr, 9'b0, bus_addr, bus_wdata}, {1'b1, 1'b1, 9'b0, 5'h04, 16'd100});
        wait_rsp(d, e, cyc);
        check("b2b second data", d, 32'd10000);
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("b2b final idle", 32'(req_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mult_bus_master

// File: doc/mult_bus_master.md
Name: mult_bus_master

Overview:
Bus initiator that drives the multiplier peripheral's cs/addr/rd/wr interface on behalf of a client.
- Accepts an operand pair through a valid/ready request port.
- Writes operand A, operand B and the init pulse into the peripheral.
- Polls the done flag, reads the 32-bit result, and returns it on a valid/ready response port.
- Sits between a core/test sequencer and the multiplier peripheral; it is the only bus master on that segment.

Parameters:
- ADDR_A, 5'h04, peripheral address of operand A
- ADDR_B, 5'h08, peripheral address of operand B
- ADDR_INIT, 5'h0C, peripheral address of init (bit 0)
- ADDR_RES, 5'h10, peripheral address of the 32-bit result
- ADDR_DONE, 5'h14, peripheral address of done (bit 0)
- TIMEOUT, 1024, maximum poll cycles before aborting; counter width $clog2(TIMEOUT+1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  operand pair valid
- req_ready  out  1  block can accept a request
- req_a  in  16  operand A
- req_b  in  16  operand B
- rsp_valid  out  1  result available
- rsp_ready  in  1  client accepts result
- rsp_data  out  32  product
- rsp_err  out  1  1 = poll timeout, rsp_data = 0
- bus_cs  out  1  peripheral select
- bus_addr  out  5  peripheral address
- bus_rd  out  1  read strobe
- bus_wr  out  1  write strobe
- bus_wdata  out  16  write data to peripheral
- bus_rdata  in  32  peripheral read data, combinational from addr/cs

Behaviour:
- Clock and reset: clk rising edge; reset synchronous, active-high.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, bus_cs=0, bus_rd=0, bus_wr=0, bus_addr=0, bus_wdata=0, operand and poll counter registers 0.
- Bus outputs are Moore outputs of the registered state. Outside an access, cs/rd/wr=0, addr=0, wdata=0.
- Write access: one cycle with cs=1, wr=1, addr, wdata. The peripheral captures it at the closing edge.
- Read access: one cycle with cs=1, rd=1, addr. bus_rdata is sampled at the closing edge.
- States and transitions:
  - IDLE: req_ready=1. On req_valid, latch req_a/req_b and go to WR_A. Accept edge = cycle N.
  - WR_A (N+1): write ADDR_A, wdata = A.
  - WR_B (N+2): write ADDR_B, wdata = B.
  - INIT_SET (N+3): write ADDR_INIT, wdata = 16'h0001.
  - INIT_CLR (N+4): write ADDR_INIT, wdata = 16'h0000. Clear the poll counter.
  - POLL (from N+5): read ADDR_DONE each cycle.
    - rdata[0]=1: go to RD_RES.
    - Otherwise increment the counter. When the counter reaches TIMEOUT with no done, set rsp_err=1, rsp_data=0, and go to RESP.
  - RD_RES: read ADDR_RES. Capture rdata into rsp_data, set rsp_err=0, go to RESP.
  - RESP: rsp_valid=1, bus idle. rsp_data/rsp_err stay stable until rsp_ready. On rsp_ready, go to IDLE.
- Minimum latency: the accept edge is N. If done is seen at the first poll, rsp_valid rises at N+7.
- req_ready is 0 in every state except IDLE; there is no request queueing.
- req_a/req_b changes after acceptance have no effect.
- Peripheral contract: the peripheral clears done when init is written 1, so a stale done is not visible after INIT_CLR.
- Reset mid-operation: returns to IDLE the next edge. Bus strobes drop the same edge, the pending response is discarded, and the peripheral is reset by the shared reset.
- rsp_ready while not in RESP is ignored.
- No arithmetic; results pass through unchanged at 32 bits.

Decomposition:
- Shared package mult_bus_pkg holds:
  - state enum (IDLE, WR_A, WR_B, INIT_SET, INIT_CLR, POLL, RD_RES, RESP);
  - address localparams;
  - the init set/clear data constants.
- No sub-module; a single FSM plus the poll counter.
- Integration top connects mult_bus_master to peripheral_mult for simulation.

Test Plan:
- Basic: req A=3, B=5 with peripheral attached.
  - Bus trace: wr 0x04/3, wr 0x08/5, wr 0x0C/1, wr 0x0C/0, then reads of 0x14 until done.
  - One read of 0x10.
  - rsp_data=32'd15, rsp_err=0.
- Max operands: A=16'hFFFF, B=16'hFFFF -> rsp_data=32'hFFFE0001. Then 0×1234 -> rsp_data=0.
- Back-pressure: hold rsp_ready=0 for 10 cycles after rsp_valid.
  - rsp_valid and rsp_data stay stable, req_ready=0, no bus activity.
  - A second req_valid asserted during this window is not accepted until one cycle after the rsp handshake.
- Timeout: stub peripheral with done stuck 0, TIMEOUT=8.
  - Exactly 8 reads of 0x14, no read of 0x10.
  - rsp_valid with rsp_err=1, rsp_data=0.
- Reset mid-op: assert reset during POLL.
  - Next edge: bus_cs/rd/wr=0, req_ready=1, rsp_valid=0.
  - A new request 7×9 then completes with rsp_data=63.
- Back-to-back: two requests, 2×2 then 100×100, with rsp_ready tied 1.
  - Responses 4 then 10000, in order.
  - The second accept occurs the cycle after the first response handshake.
